// File: rtl/arbitration_sub_module.sv
// Per-core bus-access gate: data and instruction channels, each requests the shared bus and forwards traffic only while granted.
// Optional ARB_DATA_LATCH_EN keeps the last granted read word on P_*_In after the bus response ends.
module arbitration_sub_module (
    input  logic        clk,
    input  logic        reset,
    input  logic        P_DataMem_Read,
    input  logic [3:0]  P_DataMem_Write,
    input  logic [29:0] P_DataMem_Address,
    input  logic [31:0] P_DataMem_Out,
    output logic [31:0] P_DataMem_In,
    output logic        P_DataMem_Ready,
    output logic        Bus_DataMem_Read,
    output logic [3:0]  Bus_DataMem_Write,
    output logic [29:0] Bus_DataMem_Address,
    output logic [31:0] Bus_DataMem_Out,
    input  logic [31:0] Bus_DataMem_In,
    input  logic        Bus_DataMem_Ready,
    output logic        D_Bus_RQ,
    input  logic        D_Bus_GRANT,
    input  logic        P_InstMem_Read,
    input  logic [29:0] P_InstMem_Address,
    output logic [31:0] P_InstMem_In,
    output logic        P_InstMem_Ready,
    output logic        Bus_InstMem_Read,
    output logic [29:0] Bus_InstMem_Address,
    input  logic [31:0] Bus_InstMem_In,
    input  logic        Bus_InstMem_Ready,
    output logic        I_Bus_RQ,
    input  logic        I_Bus_GRANT
);

    typedef enum logic [1:0] {IDLE, REQ, GRANTED, RELEASE} chanState_t;

    chanState_t dataState;
    chanState_t instState;
    logic       dataAccess;
    logic       instAccess;
    logic       dataFwd;
    logic       instFwd;

    assign dataAccess = P_DataMem_Read | (|P_DataMem_Write);
    assign instAccess = P_InstMem_Read;
    assign dataFwd    = (dataState == GRANTED);
    assign instFwd    = (instState == GRANTED);

    // RQ is registered alongside the state so it is high exactly in REQ and GRANTED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataState <= IDLE;
            D_Bus_RQ  <= 1'b0;
        end else begin
            case (dataState)
                IDLE: if (dataAccess) begin
                    dataState <= REQ;
                    D_Bus_RQ  <= 1'b1;
                end
                REQ: if (D_Bus_GRANT) begin
                    dataState <= GRANTED;
                end else if (!dataAccess) begin
                    dataState <= IDLE;
                    D_Bus_RQ  <= 1'b0;
                end
                GRANTED: if (!D_Bus_GRANT) begin
                    dataState <= REQ;
                end else if (!dataAccess) begin
                    dataState <= RELEASE;
                    D_Bus_RQ  <= 1'b0;
                end
                RELEASE: if (!D_Bus_GRANT && !Bus_DataMem_Ready) begin
                    dataState <= IDLE;
                end
                default: begin
                    dataState <= IDLE;
                    D_Bus_RQ  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instState <= IDLE;
            I_Bus_RQ  <= 1'b0;
        end else begin
            case (instState)
                IDLE: if (instAccess) begin
                    instState <= REQ;
                    I_Bus_RQ  <= 1'b1;
                end
                REQ: if (I_Bus_GRANT) begin
                    instState <= GRANTED;
                end else if (!instAccess) begin
                    instState <= IDLE;
                    I_Bus_RQ  <= 1'b0;
                end
                GRANTED: if (!I_Bus_GRANT) begin
                    instState <= REQ;
                end else if (!instAccess) begin
                    instState <= RELEASE;
                    I_Bus_RQ  <= 1'b0;
                end
                RELEASE: if (!I_Bus_GRANT && !Bus_InstMem_Ready) begin
                    instState <= IDLE;
                end
                default: begin
                    instState <= IDLE;
                    I_Bus_RQ  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-cycle pass-through while granted; everything isolated to 0 otherwise.
    assign Bus_DataMem_Read    = dataFwd & P_DataMem_Read;
    assign Bus_DataMem_Write   = dataFwd ? P_DataMem_Write   : 4'd0;
    assign Bus_DataMem_Address = dataFwd ? P_DataMem_Address : 30'd0;
    assign Bus_DataMem_Out     = dataFwd ? P_DataMem_Out     : 32'd0;
    assign P_DataMem_Ready     = dataFwd & Bus_DataMem_Ready;

    assign Bus_InstMem_Read    = instFwd & P_InstMem_Read;
    assign Bus_InstMem_Address = instFwd ? P_InstMem_Address : 30'd0;
    assign P_InstMem_Ready     = instFwd & Bus_InstMem_Ready;

`ifdef ARB_DATA_LATCH_EN
    logic [31:0] dataHold;
    logic [31:0] instHold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataHold <= 32'd0;
            instHold <= 32'd0;
        end else begin
            if (dataFwd && Bus_DataMem_Ready) dataHold <= Bus_DataMem_In;
            if (instFwd && Bus_InstMem_Ready) instHold <= Bus_InstMem_In;
        end
    end

    assign P_DataMem_In = (dataFwd && Bus_DataMem_Ready) ? Bus_DataMem_In : dataHold;
    assign P_InstMem_In = (instFwd && Bus_InstMem_Ready) ? Bus_InstMem_In : instHold;
`else
    assign P_DataMem_In = dataFwd ? Bus_DataMem_In : 32'd0;
    assign P_InstMem_In = instFwd ? Bus_InstMem_In : 32'd0;
`endif

endmodule

// File: tb/tb_arbitration_sub_module.sv
// Bench for arbitration_sub_module: directed scenarios plus randomized traffic against a channel model.
module tb_arbitration_sub_module;

    logic        clk = 1'b0;
    logic        reset;
    logic        P_DataMem_Read;
    logic [3:0]  P_DataMem_Write;
    logic [29:0] P_DataMem_Address;
    logic [31:0] P_DataMem_Out;
    logic [31:0] P_DataMem_In;
    logic        P_DataMem_Ready;
    logic        Bus_DataMem_Read;
    logic [3:0]  Bus_DataMem_Write;
    logic [29:0] Bus_DataMem_Address;
    logic [31:0] Bus_DataMem_Out;
    logic [31:0] Bus_DataMem_In;
    logic        Bus_DataMem_Ready;
    logic        D_Bus_RQ;
    logic        D_Bus_GRANT;
    logic        P_InstMem_Read;
    logic [29:0] P_InstMem_Address;
    logic [31:0] P_InstMem_In;
    logic        P_InstMem_Ready;
    logic        Bus_InstMem_Read;
    logic [29:0] Bus_InstMem_Address;
    logic [31:0] Bus_InstMem_In;
    logic        Bus_InstMem_Ready;
    logic        I_Bus_RQ;
    logic        I_Bus_GRANT;

    int checks = 0;
    int errors = 0;

    arbitration_sub_module dut (
        .clk(clk), .reset(reset),
        .P_DataMem_Read(P_DataMem_Read), .P_DataMem_Write(P_DataMem_Write),
        .P_DataMem_Address(P_DataMem_Address), .P_DataMem_Out(P_DataMem_Out),
        .P_DataMem_In(P_DataMem_In), .P_DataMem_Ready(P_DataMem_Ready),
        .Bus_DataMem_Read(Bus_DataMem_Read), .Bus_DataMem_Write(Bus_DataMem_Write),
        .Bus_DataMem_Address(Bus_DataMem_Address), .Bus_DataMem_Out(Bus_DataMem_Out),
        .Bus_DataMem_In(Bus_DataMem_In), .Bus_DataMem_Ready(Bus_DataMem_Ready),
        .D_Bus_RQ(D_Bus_RQ), .D_Bus_GRANT(D_Bus_GRANT),
        .P_InstMem_Read(P_InstMem_Read), .P_InstMem_Address(P_InstMem_Address),
        .P_InstMem_In(P_InstMem_In), .P_InstMem_Ready(P_InstMem_Ready),
        .Bus_InstMem_Read(Bus_InstMem_Read), .Bus_InstMem_Address(Bus_InstMem_Address),
        .Bus_InstMem_In(Bus_InstMem_In), .Bus_InstMem_Ready(Bus_InstMem_Ready),
        .I_Bus_RQ(I_Bus_RQ), .I_Bus_GRANT(I_Bus_GRANT)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Channel model as three flags: request outstanding, bus owned, draining after release.
    function automatic logic [2:0] stepChan(input logic [2:0] s, input logic acc,
                                            input logic gnt, input logic rdy);
        logic rq;
        logic own;
        logic dr;
        rq  = s[2];
        own = s[1];
        dr  = s[0];
        if (dr) begin
            dr = gnt || rdy;
        end else if (own) begin
            if (!gnt) own = 1'b0;
            else if (!acc) begin own = 1'b0; rq = 1'b0; dr = 1'b1; end
        end else if (rq) begin
            if (gnt) own = 1'b1;
            else if (!acc) rq = 1'b0;
        end else begin
            rq = acc;
        end
        return {rq, own, dr};
    endfunction

    logic [2:0]  dM;
    logic [2:0]  iM;
    logic [31:0] dHoldM;
    logic [31:0] iHoldM;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dM     <= 3'd0;
            iM     <= 3'd0;
            dHoldM <= 32'd0;
            iHoldM <= 32'd0;
        end else begin
            dM <= stepChan(dM, P_DataMem_Read || (P_DataMem_Write != 4'd0), D_Bus_GRANT, Bus_DataMem_Ready);
            iM <= stepChan(iM, P_InstMem_Read, I_Bus_GRANT, Bus_InstMem_Ready);
            if (dM[1] && Bus_DataMem_Ready) dHoldM <= Bus_DataMem_In;
            if (iM[1] && Bus_InstMem_Ready) iHoldM <= Bus_InstMem_In;
        end
    end

    logic [31:0] expDIn;
    logic [31:0] expIIn;

    always @(negedge clk) begin
`ifdef ARB_DATA_LATCH_EN
        expDIn = (dM[1] && Bus_DataMem_Ready) ? Bus_DataMem_In : dHoldM;
        expIIn = (iM[1] && Bus_InstMem_Ready) ? Bus_InstMem_In : iHoldM;
`else
        expDIn = dM[1] ? Bus_DataMem_In : 32'd0;
        expIIn = iM[1] ? Bus_InstMem_In : 32'd0;
`endif
        check("m_D_RQ", 64'(D_Bus_RQ), 64'(dM[2]));
        check("m_D_busRead", 64'(Bus_DataMem_Read), 64'(dM[1] & P_DataMem_Read));
        check("m_D_busWrite", 64'(Bus_DataMem_Write), 64'(dM[1] ? P_DataMem_Write : 4'd0));
        check("m_D_busAddr", 64'(Bus_DataMem_Address), 64'(dM[1] ? P_DataMem_Address : 30'd0));
        check("m_D_busOut", 64'(Bus_DataMem_Out), 64'(dM[1] ? P_DataMem_Out : 32'd0));
        check("m_D_pReady", 64'(P_DataMem_Ready), 64'(dM[1] & Bus_DataMem_Ready));
        check("m_D_pIn", 64'(P_DataMem_In), 64'(expDIn));
        check("m_I_RQ", 64'(I_Bus_RQ), 64'(iM[2]));
        check("m_I_busRead", 64'(Bus_InstMem_Read), 64'(iM[1] & P_InstMem_Read));
        check("m_I_busAddr", 64'(Bus_InstMem_Address), 64'(iM[1] ? P_InstMem_Address : 30'd0));
        check("m_I_pReady", 64'(P_InstMem_Ready), 64'(iM[1] & Bus_InstMem_Ready));
        check("m_I_pIn", 64'(P_InstMem_In), 64'(expIIn));
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        P_DataMem_Read = 0; P_DataMem_Write = 0; P_DataMem_Address = 0; P_DataMem_Out = 0;
        Bus_DataMem_In = 0; Bus_DataMem_Ready = 0; D_Bus_GRANT = 0;
        P_InstMem_Read = 0; P_InstMem_Address = 0; Bus_InstMem_In = 0;
        Bus_InstMem_Ready = 0; I_Bus_GRANT = 0;
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        sample();
        check("reset_idle", 64'({D_Bus_RQ, I_Bus_RQ, Bus_DataMem_Read, Bus_DataMem_Write,
                                 Bus_InstMem_Read, P_DataMem_Ready, P_InstMem_Ready}), 64'd0);
        check("reset_pIn", 64'({P_DataMem_In, P_InstMem_In}), 64'd0);

        // Data read
        nextCycle(); P_DataMem_Read = 1; P_DataMem_Address = 30'd5;
        sample(); check("rd_rq_before", 64'(D_Bus_RQ), 64'd0);
        nextCycle(); sample();
        check("rd_rq_after1", 64'(D_Bus_RQ), 64'd1);
        check("rd_isolated", 64'(Bus_DataMem_Read), 64'd0);
        nextCycle(); D_Bus_GRANT = 1;
        sample(); check("rd_no_fwd_before_grant", 64'(Bus_DataMem_Address), 64'd0);
        nextCycle(); Bus_DataMem_Ready = 1; Bus_DataMem_In = 32'd11;
        sample();
        check("rd_busRead", 64'(Bus_DataMem_Read), 64'd1);
        check("rd_busAddr", 64'(Bus_DataMem_Address), 64'd5);
        check("rd_pIn", 64'(P_DataMem_In), 64'd11);
        check("rd_pReady", 64'(P_DataMem_Ready), 64'd1);
        nextCycle(); P_DataMem_Read = 0; Bus_DataMem_Ready = 0;
        nextCycle(); sample();
        check("rd_release_rq", 64'(D_Bus_RQ), 64'd0);

        // Data write
        nextCycle(); D_Bus_GRANT = 0;
        nextCycle(); P_DataMem_Write = 4'hF; P_DataMem_Out = 32'hF; D_Bus_GRANT = 1;
        nextCycle();
        nextCycle(); sample();
        check("wr_bus", 64'({Bus_DataMem_Write, Bus_DataMem_Out, Bus_DataMem_Address}),
              64'({4'hF, 32'hF, 30'd5}));
        nextCycle(); P_DataMem_Write = 0;
        sample(); check("wr_rq_still", 64'(D_Bus_RQ), 64'd1);
        nextCycle(); sample(); check("wr_rq_low", 64'(D_Bus_RQ), 64'd0);
        P_DataMem_Write = 4'hF;
        nextCycle(); D_Bus_GRANT = 0;
        sample(); check("wr_release_holds", 64'(D_Bus_RQ), 64'd0);
        nextCycle();
        nextCycle(); sample();
        check("wr_idle_then_req", 64'(D_Bus_RQ), 64'd1);
        check("wr_req_isolated", 64'(Bus_DataMem_Write), 64'd0);
        nextCycle(); P_DataMem_Write = 0;

        // Isolation with grant withheld
        nextCycle(); P_InstMem_Read = 1; P_InstMem_Address = 30'd7;
        Bus_InstMem_Ready = 1; Bus_InstMem_In = 32'hDEADBEEF;
        for (int k = 0; k < 10; k++) begin
            nextCycle(); sample();
            check("iso_busRead", 64'({Bus_InstMem_Read, Bus_InstMem_Address}), 64'd0);
            check("iso_pReady", 64'(P_InstMem_Ready), 64'd0);
            check("iso_rq", 64'(I_Bus_RQ), 64'd1);
        end

        // Preemption and re-grant, with a concurrent data request
        nextCycle(); I_Bus_GRANT = 1;
        nextCycle(); sample();
        check("pre_fwd", 64'({Bus_InstMem_Read, P_InstMem_In}), 64'({1'b1, 32'hDEADBEEF}));
        nextCycle(); I_Bus_GRANT = 0; P_DataMem_Read = 1; P_DataMem_Address = 30'd9;
        sample(); check("pre_still_fwd", 64'(Bus_InstMem_Read), 64'd1);
        nextCycle(); sample();
        check("pre_dropped", 64'(Bus_InstMem_Read), 64'd0);
        check("pre_rq_kept", 64'(I_Bus_RQ), 64'd1);
        I_Bus_GRANT = 1;
        nextCycle(); sample();
        check("cc_inst_fwd", 64'(Bus_InstMem_Read), 64'd1);
        check("cc_data_wait", 64'({D_Bus_RQ, Bus_DataMem_Read}), 64'b10);
        D_Bus_GRANT = 1;
        nextCycle(); sample();
        check("cc_both_fwd", 64'({Bus_DataMem_Read, Bus_InstMem_Read}), 64'b11);
        #2 reset = 1'b1;
        #1 check("async_reset", 64'({D_Bus_RQ, I_Bus_RQ, Bus_DataMem_Read, Bus_InstMem_Read}), 64'd0);
        nextCycle(); reset = 1'b0; clearInputs();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            nextCycle();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                P_DataMem_Read  = ($urandom_range(0, 1) == 1);
                P_DataMem_Write = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            end
            if ($urandom_range(0, 3) == 0) P_InstMem_Read = ~P_InstMem_Read;
            if ($urandom_range(0, 2) == 0) D_Bus_GRANT = ~D_Bus_GRANT;
            if ($urandom_range(0, 2) == 0) I_Bus_GRANT = ~I_Bus_GRANT;
            P_DataMem_Address = 30'($urandom);
            P_DataMem_Out     = $urandom;
            P_InstMem_Address = 30'($urandom);
            Bus_DataMem_In    = $urandom;
            Bus_InstMem_In    = $urandom;
            Bus_DataMem_Ready = ($urandom_range(0, 1) == 1);
            Bus_InstMem_Ready = ($urandom_range(0, 1) == 1);
        end
        nextCycle();
        sample();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitration_sub_module.md
# arbitration_sub_module

Per-core bus-access gate between one processor and the shared data and instruction buses. It has two independent channels, data and instruction. Each channel raises a request to the bus arbiter when the processor starts an access. Once the arbiter grants, it forwards processor signals to the bus and bus responses back to the processor. At all other times it isolates the core from the bus.

## Interface
- No parameters; widths fixed: address 30, data 32, byte-write enables 4.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces both channels to IDLE.
- P_DataMem_Read  in  1  processor data read request.
- P_DataMem_Write  in  4  processor byte-write enables; nonzero = write request.
- P_DataMem_Address  in  30  processor data word address.
- P_DataMem_Out  in  32  processor write data.
- P_DataMem_In  out  32  read data to processor.
- P_DataMem_Ready  out  1  data access complete, to processor.
- Bus_DataMem_Read  out  1  read strobe to data bus.
- Bus_DataMem_Write  out  4  byte-write enables to data bus.
- Bus_DataMem_Address  out  30  address to data bus.
- Bus_DataMem_Out  out  32  write data to data bus.
- Bus_DataMem_In  in  32  read data from data bus.
- Bus_DataMem_Ready  in  1  data bus response valid.
- D_Bus_RQ  out  1  data bus request to arbiter.
- D_Bus_GRANT  in  1  data bus grant from arbiter.
- P_InstMem_Read  in  1  processor fetch request.
- P_InstMem_Address  in  30  fetch word address.
- P_InstMem_In  out  32  instruction to processor.
- P_InstMem_Ready  out  1  fetch complete, to processor.
- Bus_InstMem_Read  out  1  read strobe to instruction bus.
- Bus_InstMem_Address  out  30  address to instruction bus.
- Bus_InstMem_In  in  32  instruction from bus.
- Bus_InstMem_Ready  in  1  instruction bus response valid.
- I_Bus_RQ  out  1  instruction bus request to arbiter.
- I_Bus_GRANT  in  1  instruction bus grant from arbiter.

## Operation
- The two channels are identical, independent 4-state Moore FSMs. Access = Read, or Write≠0 (data); Read (instruction).
- IDLE: RQ=0, bus isolated. Access=1 → REQ.
- REQ: RQ=1, bus isolated. GRANT=1 → GRANTED. Access=0 (abandoned) → IDLE.
- GRANTED: RQ=1. Bus outputs = processor inputs, combinational. P_Ready = Bus_Ready. P_In = Bus_In. GRANT=0 (preempted) → REQ. Access=0 → RELEASE.
- RELEASE: RQ=0, bus isolated. GRANT=0 and Bus_Ready=0 → IDLE; otherwise stay.
- Isolated means Bus Read=0, Write=0, Address=0, Out=0, P_Ready=0, and P_In=0 (except as in Configuration).
- GRANT while IDLE or RELEASE is ignored. Bus_Ready outside GRANTED is ignored.
- Reset: both FSMs go to IDLE immediately. All outputs go to 0.

## Timing
- Access sampled at edge k → RQ high after edge k, one cycle of latency.
- GRANT sampled at edge g → pass-through active after edge g.
- While GRANTED, bus↔processor paths are zero-cycle combinational, with no registers.
- Access deasserted at edge r → RQ low and bus isolated after edge r.
- Minimum request-to-forwarding latency is 2 edges.
- Reset asserted mid-transaction drops RQ and the bus strobes asynchronously.

## Configuration
- ARB_DATA_LATCH_EN defined:
  - Each channel has a 32-bit hold register, reset 0.
  - It loads Bus_In on each edge where the FSM is GRANTED and Bus_Ready=1.
  - When not (GRANTED and Bus_Ready), P_In = hold register instead of 0.
  - P_Ready is unchanged.
- ARB_DATA_LATCH_EN undefined: no hold register; P_In = 0 whenever not GRANTED.

## Test plan
- Reset held 5 cycles, then released with no access → all outputs 0, both RQ=0, FSMs IDLE.
- Data read:
  - Stimulus: P_DataMem_Read=1, Address=5; GRANT after 2 cycles; bus returns Ready=1, In=11.
  - Required: D_Bus_RQ=1 one cycle after the request. Bus_DataMem_Read=1 and Bus_DataMem_Address=5 only after GRANT. P_DataMem_In=11 and P_DataMem_Ready=1 in the same cycle.
- Data write, Write=4'b1111, Out=0xF, Address=5, granted → bus shows 4'b1111/0xF/5. Write=0 → RQ low next edge; IDLE after GRANT=0 and Ready=0.
- Isolation: processor access active, GRANT held 0 for 10 cycles → bus outputs stay 0, P_Ready=0, RQ=1.
- Preemption: GRANT drops while instruction fetch is GRANTED → Bus_InstMem_Read=0 next edge, I_Bus_RQ stays 1, forwarding resumes on re-grant.
- Concurrent: data and instruction requests with grants at different times → each channel forwards only on its own grant. Reset mid-transfer clears both RQs asynchronously.
